ps2_key_decoder: RTL

//  Receives PS/2 keyboard frames and turns scan-code sequences into a held key code.

---
 rtl/ps2_key_if.sv | 27 ++
 rtl/ps2_key_decoder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_if.sv
// PS/2 keyboard pins and decoded key outputs, shared by the decoder and its host.
interface ps2_key_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_valid;
  logic       frame_err;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  key_code,
    input  key_ext,
    input  key_valid,
    input  frame_err
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output key_code,
    output key_ext,
    output key_valid,
    output frame_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: turns F0/E0 scan-code sequences into a held make code.
// Define PS2_FRAME_CHECK_EN to reject frames with bad odd parity or a low stop bit.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic     clk,
  input  logic     rst,
  ps2_key_if.slave bus
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_EXT = 8'hE0;

`ifdef PS2_FRAME_CHECK_EN
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction
`endif

  logic [1:0]    clk_sync_r;
  logic [1:0]    data_sync_r;
  logic          clk_prev_r;
  logic          fall_s;
  logic          data_s;

  logic [1:0]    state_r;
  logic [2:0]    bitcnt_r;
  logic [7:0]    shift_r;
  logic [TW-1:0] to_cnt_r;
  logic          frame_done_r;
`ifdef PS2_FRAME_CHECK_EN
  logic          par_r;
  logic          stop_r;
`endif
  logic          frame_bad_s;
  logic          match_s;

  logic [7:0]    key_code_r;
  logic          key_ext_r;
  logic          key_valid_r;
  logic          frame_err_r;
  logic          brk_r;
  logic          ext_r;

  // Two-flop synchronizers, preloaded to the idle-high bus level
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
      clk_prev_r  <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], bus.ps2_clk};
      data_sync_r <= {data_sync_r[0], bus.ps2_data};
      clk_prev_r  <= clk_sync_r[1];
    end
  end

  assign fall_s = clk_prev_r & ~clk_sync_r[1];
  assign data_s = data_sync_r[1];

  // Frame receiver with mid-frame inactivity timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      bitcnt_r     <= 3'd0;
      shift_r      <= 8'h00;
      to_cnt_r     <= '0;
      frame_done_r <= 1'b0;
`ifdef PS2_FRAME_CHECK_EN
      par_r        <= 1'b0;
      stop_r       <= 1'b0;
`endif
    end else begin
      frame_done_r <= 1'b0;
      if ((state_r != ST_IDLE) && !fall_s && (to_cnt_r == TO_LAST)) begin
        // abandoned frame: drop it silently
        state_r  <= ST_IDLE;
        to_cnt_r <= '0;
      end else begin
        if ((state_r == ST_IDLE) || fall_s) begin
          to_cnt_r <= '0;
        end else begin
          to_cnt_r <= to_cnt_r + TO_ONE;
        end
        if (fall_s) begin
          case (state_r)
            ST_IDLE: begin
              if (!data_s) begin
                state_r  <= ST_DATA;
                bitcnt_r <= 3'd0;
              end
            end
            ST_DATA: begin
              shift_r  <= {data_s, shift_r[7:1]};
              bitcnt_r <= bitcnt_r + 3'd1;
              if (bitcnt_r == 3'd7) begin
                state_r <= ST_PARITY;
              end
            end
            ST_PARITY: begin
`ifdef PS2_FRAME_CHECK_EN
              par_r   <= data_s;
`endif
              state_r <= ST_STOP;
            end
            ST_STOP: begin
`ifdef PS2_FRAME_CHECK_EN
              stop_r  <= data_s;
`endif
              frame_done_r <= 1'b1;
              state_r      <= ST_IDLE;
            end
            default: begin
              state_r <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

`ifdef PS2_FRAME_CHECK_EN
  assign frame_bad_s = !odd_parity_ok(shift_r, par_r) || !stop_r;
`else
  assign frame_bad_s = 1'b0;
`endif

  assign match_s = (shift_r == key_code_r) && (ext_r == key_ext_r);

  // Scan-code decoder: prefix flags, held key and output pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      key_code_r  <= 8'h00;
      key_ext_r   <= 1'b0;
      key_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
      brk_r       <= 1'b0;
      ext_r       <= 1'b0;
    end else begin
      key_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
      if (frame_done_r) begin
        if (frame_bad_s) begin
          frame_err_r <= 1'b1;
        end else if (shift_r == CODE_BRK) begin
          brk_r <= 1'b1;
        end else if (shift_r == CODE_EXT) begin
          ext_r <= 1'b1;
        end else if (brk_r) begin
          // a break for anything but the held key is stale and ignored
          if (match_s) begin
            key_code_r <= 8'h00;
            key_ext_r  <= 1'b0;
          end
          brk_r <= 1'b0;
          ext_r <= 1'b0;
        end else begin
          key_code_r  <= shift_r;
          key_ext_r   <= ext_r;
          key_valid_r <= 1'b1;
          ext_r       <= 1'b0;
        end
      end
    end
  end

  assign bus.key_code  = key_code_r;
  assign bus.key_ext   = key_ext_r;
  assign bus.key_valid = key_valid_r;
  assign bus.frame_err = frame_err_r;

endmodule
